// File: rtl/move_unit.sv
// Move/transfer unit for the memory-access stage: MOVZ/MOVN, HI/LO moves with local
// HI/LO storage, and MFC0/MTC0 run as stalling request/acknowledge transactions to CP0.
module move_unit #(
  parameter int DATA_WIDTH     = 32,
  parameter int CP0_ADDR_WIDTH = 5,
  parameter int CP0_SEL_WIDTH  = 3,
  parameter int TIMEOUT        = 15
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  input  logic [3:0]                op,
  input  logic [31:0]               raw_inst,
  input  logic [DATA_WIDTH-1:0]     data,
  input  logic [DATA_WIDTH-1:0]     cond,
  input  logic                      hilo_we,
  input  logic [DATA_WIDTH-1:0]     hi_in,
  input  logic [DATA_WIDTH-1:0]     lo_in,
  output logic                      cp0_req,
  output logic                      cp0_we,
  output logic [CP0_ADDR_WIDTH-1:0] cp0_addr,
  output logic [CP0_SEL_WIDTH-1:0]  cp0_sel,
  output logic [DATA_WIDTH-1:0]     cp0_wdata,
  input  logic                      cp0_ack,
  input  logic [DATA_WIDTH-1:0]     cp0_rdata,
  output logic [DATA_WIDTH-1:0]     res,
  output logic                      res_we,
  output logic                      stall,
  output logic                      cp0_err,
  output logic [DATA_WIDTH-1:0]     hi_out,
  output logic [DATA_WIDTH-1:0]     lo_out
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  localparam logic [3:0] OP_MOVZ = 4'd1;
  localparam logic [3:0] OP_MOVN = 4'd2;
  localparam logic [3:0] OP_MFHI = 4'd3;
  localparam logic [3:0] OP_MFLO = 4'd4;
  localparam logic [3:0] OP_MTHI = 4'd5;
  localparam logic [3:0] OP_MTLO = 4'd6;
  localparam logic [3:0] OP_MFC0 = 4'd7;
  localparam logic [3:0] OP_MTC0 = 4'd8;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_DONE} state_t;

  state_t r_state, w_state_nxt;

  logic [DATA_WIDTH-1:0]     r_res, w_res_nxt;
  logic                      r_res_we, w_res_we_nxt;
  logic                      r_cp0_req, w_cp0_req_nxt;
  logic                      r_cp0_we, w_cp0_we_nxt;
  logic [CP0_ADDR_WIDTH-1:0] r_cp0_addr, w_cp0_addr_nxt;
  logic [CP0_SEL_WIDTH-1:0]  r_cp0_sel, w_cp0_sel_nxt;
  logic [DATA_WIDTH-1:0]     r_cp0_wdata, w_cp0_wdata_nxt;
  logic                      r_cp0_err, w_cp0_err_nxt;
  logic [CNT_W-1:0]          r_cnt, w_cnt_nxt;
  logic [DATA_WIDTH-1:0]     r_hi, w_hi_nxt;
  logic [DATA_WIDTH-1:0]     r_lo, w_lo_nxt;

  logic w_is_cp0;
  logic w_timeout;
  logic w_unused_bits;

  assign w_is_cp0  = (op == OP_MFC0) || (op == OP_MTC0);
  assign w_timeout = (r_state == S_REQ) && !cp0_ack && (r_cnt == CNT_W'(TIMEOUT - 1));

  // Instruction bits outside the CP0 register/select fields are intentionally ignored.
  assign w_unused_bits = ^{raw_inst[31:11+CP0_ADDR_WIDTH], raw_inst[10:CP0_SEL_WIDTH]};

  // NOTE: reset is sampled on the clock edge only; rst_n is not in the sensitivity list.
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_REQ:   if (cp0_ack || w_timeout) w_state_nxt = S_DONE;
      default: w_state_nxt = (in_valid && w_is_cp0) ? S_REQ : S_IDLE;
    endcase
  end

  // NOTE: every comb output gets a default first so no path leaves it unassigned (no latches).
  always_comb begin
    w_res_nxt       = '0;
    w_res_we_nxt    = 1'b0;
    w_cp0_err_nxt   = 1'b0;
    w_cp0_req_nxt   = r_cp0_req;
    w_cp0_we_nxt    = r_cp0_we;
    w_cp0_addr_nxt  = r_cp0_addr;
    w_cp0_sel_nxt   = r_cp0_sel;
    w_cp0_wdata_nxt = r_cp0_wdata;
    w_cnt_nxt       = r_cnt;
    w_hi_nxt        = r_hi;
    w_lo_nxt        = r_lo;
    stall           = 1'b0;

    if (r_state == S_REQ) begin
      stall = 1'b1;
      if (cp0_ack) begin
        w_cp0_req_nxt = 1'b0;
        w_res_nxt     = r_cp0_we ? '0 : cp0_rdata;
        w_res_we_nxt  = !r_cp0_we;
      end else if (w_timeout) begin
        w_cp0_req_nxt = 1'b0;
        w_cp0_err_nxt = 1'b1;
      end else begin
        w_cnt_nxt = r_cnt + 1'b1;
      end
    end else if (in_valid) begin
      stall = w_is_cp0;
      case (op)
        OP_MOVZ: begin w_res_nxt = data; w_res_we_nxt = (cond == '0); end
        OP_MOVN: begin w_res_nxt = data; w_res_we_nxt = (cond != '0); end
        OP_MFHI: begin w_res_nxt = r_hi; w_res_we_nxt = 1'b1; end
        OP_MFLO: begin w_res_nxt = r_lo; w_res_we_nxt = 1'b1; end
        OP_MTHI: w_hi_nxt = data;
        OP_MTLO: w_lo_nxt = data;
        OP_MFC0, OP_MTC0: begin
          w_cp0_req_nxt   = 1'b1;
          w_cp0_we_nxt    = (op == OP_MTC0);
          w_cp0_addr_nxt  = raw_inst[11 +: CP0_ADDR_WIDTH];
          w_cp0_sel_nxt   = raw_inst[CP0_SEL_WIDTH-1:0];
          w_cp0_wdata_nxt = (op == OP_MTC0) ? data : '0;
          w_cnt_nxt       = '0;
        end
        default: ;
      endcase
    end

    // muldiv in EX is the younger instruction, so its HI/LO write wins.
    if (hilo_we) begin
      w_hi_nxt = hi_in;
      w_lo_nxt = lo_in;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_res       <= '0;
      r_res_we    <= 1'b0;
      r_cp0_req   <= 1'b0;
      r_cp0_we    <= 1'b0;
      r_cp0_addr  <= '0;
      r_cp0_sel   <= '0;
      r_cp0_wdata <= '0;
      r_cp0_err   <= 1'b0;
      r_cnt       <= '0;
      r_hi        <= '0;
      r_lo        <= '0;
    end else begin
      r_res       <= w_res_nxt;
      r_res_we    <= w_res_we_nxt;
      r_cp0_req   <= w_cp0_req_nxt;
      r_cp0_we    <= w_cp0_we_nxt;
      r_cp0_addr  <= w_cp0_addr_nxt;
      r_cp0_sel   <= w_cp0_sel_nxt;
      r_cp0_wdata <= w_cp0_wdata_nxt;
      r_cp0_err   <= w_cp0_err_nxt;
      r_cnt       <= w_cnt_nxt;
      r_hi        <= w_hi_nxt;
      r_lo        <= w_lo_nxt;
    end
  end

  assign res       = r_res;
  assign res_we    = r_res_we;
  assign cp0_req   = r_cp0_req;
  assign cp0_we    = r_cp0_we;
  assign cp0_addr  = r_cp0_addr;
  assign cp0_sel   = r_cp0_sel;
  assign cp0_wdata = r_cp0_wdata;
  assign cp0_err   = r_cp0_err;
  assign hi_out    = r_hi;
  assign lo_out    = r_lo;

endmodule

// File: doc/move_unit.md
# move_unit

Parametrised move/transfer unit in the memory-access stage. It executes MOVZ/MOVN and MFHI/MFLO/MTHI/MTLO, with HI/LO storage kept inside the block. It runs MFC0/MTC0 as multi-cycle request/acknowledge transactions to the CP0 block, stalling the pipeline while they are outstanding. Results go to the MEM/WB register as a registered value plus a write-enable.

## Interface
Parameters:
- DATA_WIDTH, 32, width of GPR, HI, LO and CP0 data.
- CP0_ADDR_WIDTH, 5, CP0 register number width (taken from raw_inst[15:11]).
- CP0_SEL_WIDTH, 3, CP0 select width (taken from raw_inst[CP0_SEL_WIDTH-1:0]).
- TIMEOUT, 15, maximum cycles in REQ before abort; counter width $clog2(TIMEOUT+1).

Ports:
- clk  in  1  clock, all state on rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- in_valid  in  1  op/operands valid this cycle.
- op  in  4  0 NOP, 1 MOVZ, 2 MOVN, 3 MFHI, 4 MFLO, 5 MTHI, 6 MTLO, 7 MFC0, 8 MTC0; 9-15 are treated as NOP.
- raw_inst  in  32  instruction word, source of the CP0 address and select.
- data  in  DATA_WIDTH  rs value (MOVZ/MOVN, MTHI/MTLO) or rt value (MTC0).
- cond  in  DATA_WIDTH  rt value, the MOVZ/MOVN test operand.
- hilo_we  in  1  muldiv writes HI and LO this cycle.
- hi_in, lo_in  in  DATA_WIDTH  muldiv results.
- cp0_req  out  1  CP0 transaction request.
- cp0_we  out  1  1 = write (MTC0), 0 = read (MFC0).
- cp0_addr  out  CP0_ADDR_WIDTH  CP0 register number.
- cp0_sel  out  CP0_SEL_WIDTH  CP0 select.
- cp0_wdata  out  DATA_WIDTH  MTC0 data.
- cp0_ack  in  1  CP0 completes the transaction this cycle.
- cp0_rdata  in  DATA_WIDTH  read data, valid while cp0_ack=1.
- res  out  DATA_WIDTH  GPR write value.
- res_we  out  1  GPR write enable.
- stall  out  1  hold the pipeline and the inputs.
- cp0_err  out  1  one-cycle pulse on a CP0 timeout.
- hi_out, lo_out  out  DATA_WIDTH  current HI/LO register values.

## Operation
- States: IDLE, REQ, DONE. Reset puts the block in IDLE.
- Reset values: res, res_we, cp0_req, cp0_we, cp0_addr, cp0_sel, cp0_wdata, cp0_err, HI, LO and the timeout counter are all 0.
- IDLE/DONE with in_valid and a non-CP0 op: result is registered at the next edge and the state stays/returns to IDLE.
  - MOVZ: res=data; res_we=(cond==0).
  - MOVN: res=data; res_we=(cond!=0).
  - MFHI/MFLO: res=HI/LO as held before this edge; res_we=1.
  - MTHI/MTLO: write HI/LO; res=0, res_we=0.
  - NOP, or in_valid=0: res=0, res_we=0.
- IDLE/DONE with in_valid and MFC0/MTC0: latch cp0_addr, cp0_sel, cp0_we, and cp0_wdata (=data for MTC0, 0 for MFC0). Go to REQ with cp0_req=1 and the counter cleared. res_we=0.
- REQ: cp0_req and the other cp0_* outputs are held stable.
  - cp0_ack=1: clear cp0_req; res=cp0_rdata for MFC0, else 0; res_we=~cp0_we; go to DONE.
  - No ack and counter==TIMEOUT-1: clear cp0_req; res=0, res_we=0, cp0_err=1; go to DONE.
  - Otherwise increment the counter.
- DONE: behaves like IDLE for a new op; cp0_err and res_we last exactly one cycle.
- stall (combinational) = (state∈{IDLE,DONE} & in_valid & op∈{MFC0,MTC0}) | (state==REQ).
- HI/LO write priority at one edge: hilo_we overrides MTHI/MTLO, because muldiv in EX is younger. MTHI writes only HI, MTLO only LO.
- cp0_ack outside REQ is ignored.
- Reset during REQ: the next edge forces IDLE with every output at its reset value. No ack is required afterwards.

## Timing
- Non-CP0 ops: latency 1; res/res_we are valid the cycle after in_valid.
- CP0 op accepted at cycle T: cp0_req=1 from T+1. With ack at cycle A, res/res_we are valid at A+1 and stall is low at A+1. Minimum CP0 latency is 2 (ack at T+1 gives result at T+2).
- Timeout: cp0_req is high for exactly TIMEOUT cycles (T+1..T+TIMEOUT); cp0_err=1 and stall=0 at T+TIMEOUT+1.
- While stall=1 the pipeline holds in_valid/op/data unchanged. The block re-samples them only in IDLE/DONE.

## Test plan
- MOVZ data=0x1234, cond=0 → next cycle res=0x1234, res_we=1. MOVN with the same operands → res_we=0.
- MTHI data=0xAAAA0000, then MFHI → res=0xAAAA0000. MTLO with hilo_we=1 and lo_in=5 in the same cycle → LO=5.
- MFC0 raw_inst[15:11]=12, ack at 3rd REQ cycle with rdata=0xDEADBEEF → cp0_addr=12; stall high 4 cycles (acceptance cycle + 3 REQ cycles); res=0xDEADBEEF, res_we=1 the following cycle.
- MTC0 data=0x55 to reg 9, ack at T+1 → cp0_we=1, cp0_wdata=0x55; res_we=0; stall high T..T+1.
- MFC0 with no ack, TIMEOUT=15 → cp0_req high 15 cycles, cp0_err pulse, res_we=0, then a MFLO completes normally.
- rst_n=0 during REQ → cp0_req=0 at the next edge, state IDLE; a later ack produces no res_we.
